// File: rtl/passcode_pkg.sv
// passcode_pkg: shared state encoding and default sizes for the passcode checker.
package passcode_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    CHECK   = 3'd1,
    GRANT   = 3'd2,
    DENY    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_NUM_DIGITS = 4;

endpackage

// File: rtl/passcode_shift_checker_lockout_timer.sv
// lockout_timer: loadable down-counter with a zero flag; stops at zero.
module lockout_timer #(
  parameter int WIDTH = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; the count parks at zero until reloaded.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/passcode_shift_checker.sv
// passcode_shift_checker: shifts keypad digits into an N-digit window, compares
// the window with the stored code, and enforces a retry limit with a timed lockout.
// Optional build macro PASSCODE_TIMEOUT_EN adds an inter-digit idle timeout that
// discards a partial entry without consuming a try.
module passcode_shift_checker
  import passcode_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1024
`ifdef PASSCODE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              En,
  input  logic                              Load,
  input  logic [DIGIT_W-1:0]                Digit,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     Code,
  input  logic                              Clear,
  output logic                              Unlock,
  output logic                              Fail,
  output logic                              Locked,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   DigitCount,
  output logic [$clog2(MAX_TRIES+1)-1:0]    TriesLeft
);

  localparam int WW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] ALL_TRIES  = TW'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);

  state_t         state, state_n;
  logic [WW-1:0]  window, window_n;
  logic [CW-1:0]  count_n;
  logic [TW-1:0]  tries_n;
  logic           unlock_n, fail_n, locked_n;
  logic           load_q;
  logic           accept;
  logic           lock_load, lock_dec, lock_zero;

  assign accept = Load && !load_q;

  lockout_timer #(.WIDTH(LW)) u_lock_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (lock_load),
    .load_value (LOCK_LOAD),
    .dec        (lock_dec),
    .zero       (lock_zero)
  );

`ifdef PASSCODE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT_CYCLES - 1);

  logic idle_load, idle_dec, idle_zero, idle_expired;

  assign idle_dec     = (state == COLLECT) && (DigitCount != '0);
  assign idle_expired = idle_zero && (DigitCount != '0);

  lockout_timer #(.WIDTH(IW)) u_idle_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (idle_load),
    .load_value (IDLE_LOAD),
    .dec        (idle_dec),
    .zero       (idle_zero)
  );
`endif

  // Next-state and next-output decode; En low aborts everything except a lockout.
  always_comb begin
    state_n   = state;
    window_n  = window;
    count_n   = DigitCount;
    tries_n   = TriesLeft;
    unlock_n  = Unlock;
    fail_n    = 1'b0;
    locked_n  = Locked;
    lock_load = 1'b0;
    lock_dec  = 1'b0;
`ifdef PASSCODE_TIMEOUT_EN
    idle_load = 1'b0;
`endif
    if (!En && (state != LOCKOUT)) begin
      state_n  = COLLECT;
      window_n = '0;
      count_n  = '0;
      unlock_n = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (Clear) begin
            window_n = '0;
            count_n  = '0;
          end else if (DigitCount == FULL_COUNT) begin
            state_n = CHECK;
`ifdef PASSCODE_TIMEOUT_EN
          end else if (idle_expired) begin
            window_n = '0;
            count_n  = '0;
`endif
          end else if (accept) begin
            window_n = {window[WW-DIGIT_W-1:0], Digit};
            count_n  = DigitCount + 1'b1;
`ifdef PASSCODE_TIMEOUT_EN
            idle_load = 1'b1;
`endif
          end
        end
        CHECK: begin
          window_n = '0;
          count_n  = '0;
          if (Clear) begin
            state_n = COLLECT;
          end else if (window == Code) begin
            state_n  = GRANT;
            unlock_n = 1'b1;
            tries_n  = ALL_TRIES;
          end else begin
            state_n = DENY;
            fail_n  = 1'b1;
            tries_n = (TriesLeft == '0) ? '0 : TriesLeft - 1'b1;
          end
        end
        GRANT: begin
          if (Clear) begin
            state_n  = COLLECT;
            unlock_n = 1'b0;
          end
        end
        DENY: begin
          if (TriesLeft == '0) begin
            state_n   = LOCKOUT;
            locked_n  = 1'b1;
            lock_load = 1'b1;
          end else begin
            state_n = COLLECT;
          end
        end
        LOCKOUT: begin
          if (lock_zero) begin
            state_n  = COLLECT;
            locked_n = 1'b0;
            tries_n  = ALL_TRIES;
          end else begin
            lock_dec = 1'b1;
          end
        end
        default: begin
          state_n  = COLLECT;
          window_n = '0;
          count_n  = '0;
          unlock_n = 1'b0;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; load_q follows Load in every state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= COLLECT;
      window     <= '0;
      DigitCount <= '0;
      TriesLeft  <= ALL_TRIES;
      Unlock     <= 1'b0;
      Fail       <= 1'b0;
      Locked     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state      <= state_n;
      window     <= window_n;
      DigitCount <= count_n;
      TriesLeft  <= tries_n;
      Unlock     <= unlock_n;
      Fail       <= fail_n;
      Locked     <= locked_n;
      load_q     <= Load;
    end
  end

endmodule

// File: doc/passcode_shift_checker.md
Name: passcode_shift_checker

Overview:
- Receiving end of the passcode keypad datapath.
- Consumes the 4-bit digit and the load strobe from the digit register, shifts digits into an N-digit window and compares the window against the stored code.
- Drives Unlock / Fail / Locked to the medicine-reminder dispenser control.
- Enforces a retry limit with a timed lockout.

Parameters:
- NUM_DIGITS, 4, digits per passcode.
- DIGIT_W, 4, bits per digit.
- MAX_TRIES, 3, wrong entries allowed before lockout (>=1).
- LOCKOUT_CYCLES, 1024, Clk cycles spent in LOCKOUT (>=2).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  block enable; low forces idle (see Behaviour).
- Load  in  1  load strobe from digit register; level, may stay high several cycles.
- Digit  in  DIGIT_W  digit value, valid whenever Load is high.
- Code  in  NUM_DIGITS*DIGIT_W  stored passcode; first-entered digit in the MS nibble; quasi-static.
- Clear  in  1  synchronous abort/relock; discards partial entry.
- Unlock  out  1  held high in GRANT.
- Fail  out  1  one-cycle pulse on wrong code.
- Locked  out  1  high during LOCKOUT.
- DigitCount  out  $clog2(NUM_DIGITS+1)  digits collected so far.
- TriesLeft  out  $clog2(MAX_TRIES+1)  remaining attempts.

Behaviour:
- Reset (Rst=0, async):
  - state=COLLECT, window=0, DigitCount=0, TriesLeft=MAX_TRIES.
  - Unlock=0, Fail=0, Locked=0, load_q=0.
  - All outputs are registered.
- Digit acceptance:
  - A digit is accepted on a posedge where Load=1 and load_q=0 (rising edge). load_q<=Load every cycle, regardless of state.
  - A Load held N cycles yields exactly one digit.
  - On acceptance, in COLLECT only: window <= {window[rest], Digit}, DigitCount++.
- States:
  - COLLECT: accept digits. When the accepted digit makes DigitCount==NUM_DIGITS, next state is CHECK.
  - CHECK (1 cycle):
    - window==Code: go to GRANT, Unlock<=1, TriesLeft<=MAX_TRIES.
    - Otherwise: go to DENY, Fail<=1, TriesLeft--.
    - DigitCount<=0, window<=0 on either outcome.
  - GRANT: Unlock held high. Load edges are ignored. Clear returns to COLLECT with Unlock<=0.
  - DENY (1 cycle): Fail<=0.
    - If TriesLeft==0: go to LOCKOUT, Locked<=1, timer loaded to LOCKOUT_CYCLES-1.
    - Else: go to COLLECT.
  - LOCKOUT: timer decrements each cycle. Load and Clear are ignored. At timer==0: Locked<=0, TriesLeft<=MAX_TRIES, go to COLLECT.
- Latency: capturing posedge of the last digit = cycle T; CHECK at T+1; Unlock/Fail visible after posedge T+2.
- Clear:
  - In COLLECT or CHECK: window=0, DigitCount=0, state=COLLECT. TriesLeft is unchanged.
  - Clear has priority over a simultaneous Load edge.
- En=0 (synchronous):
  - State returns to COLLECT, window/DigitCount cleared, Unlock=0, Fail=0. TriesLeft is preserved.
  - LOCKOUT is exempt: the timer keeps running and Locked stays high.
  - load_q still tracks Load, so a Load held high across the En rise is not accepted.
- Code change mid-entry is not guarded; the comparison uses Code as sampled in CHECK.
- Reset asserted mid-entry or mid-lockout: immediate return to reset values.

Optional Feature:
- PASSCODE_TIMEOUT_EN:
  - Defined: adds parameter TIMEOUT_CYCLES (default 4096) and an inter-digit idle counter.
  - The counter resets on each accepted digit.
  - If DigitCount>0 and the counter reaches TIMEOUT_CYCLES-1 in COLLECT, the partial entry is discarded as for Clear, with no try consumed.
  - Undefined: a partial entry waits indefinitely.

Decomposition:
- Package passcode_pkg holds:
  - State enum: COLLECT, CHECK, GRANT, DENY, LOCKOUT.
  - Default constants for DIGIT_W, NUM_DIGITS.
- One sub-module, lockout_timer: load/decrement/zero-flag down-counter.
  - Used for LOCKOUT.
  - Reused for the inter-digit timeout when PASSCODE_TIMEOUT_EN is defined.

Test Plan:
- Code=16'h1234; Load pulses with Digit 1,2,3,4 -> Unlock=1 two cycles after the 4th edge; TriesLeft=3; Clear -> Unlock=0, DigitCount=0.
- Code=16'h1234; digits 1,2,3,5 -> single-cycle Fail; TriesLeft 3->2; DigitCount=0.
- Three wrong entries (LOCKOUT_CYCLES=16) -> Locked=1 for 16 cycles; Load edges during lockout change nothing; afterwards TriesLeft=3.
- Load held high 5 cycles with Digit=7 -> DigitCount=1, window LS nibble=7; wrong then right entry -> TriesLeft restored to 3 on Unlock.
- Rst pulled low after 2 digits -> all outputs at reset values immediately (async); next 1,2,3,4 -> Unlock.
- En low after 3 digits, then high -> DigitCount=0; Load edge coincident with Clear -> not accepted.
